// File: rtl/fifo_pkg.sv
// Shared definitions for the sync FIFO family and its stream reader.
// Contents:
//   DATA_WIDTH_DEF : default payload width
//   ptr_width()    : bit width needed to index/count 'depth' distinct values
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  // Number of bits needed to represent values 0..depth-1 (minimum 1).
  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Bus bundle between a sync FIFO read port, the stream reader and a
// valid/ready sink.
// Signals:
//   fifo_empty  FIFO empty flag
//   fifo_rd_en  pop request to the FIFO
//   fifo_rdata  FIFO read data, valid the cycle after an accepted pop
//   m_valid     stream word valid
//   m_ready     sink ready
//   m_data      stream payload
// Stream handshake: a word transfers on every rising edge where m_valid and
// m_ready are both 1; once m_valid is raised, m_valid and m_data hold until
// that transfer happens (m_valid never depends on m_ready).
// Modports: master = the reader, slave = the FIFO/sink environment.
interface fifo_stream_reader_if #(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH_DEF
);
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (
    input  fifo_empty, fifo_rdata, m_ready,
    output fifo_rd_en, m_valid, m_data
  );

  modport slave (
    output fifo_empty, fifo_rdata, m_ready,
    input  fifo_rd_en, m_valid, m_data
  );
endinterface

// File: rtl/fifo_stream_skid_buf.sv
// Small circular skid buffer with head/tail pointers and occupancy count.
// Ports:
//   clk, rst    clock, synchronous active-high reset (also clears storage)
//   clr         synchronous clear of pointers/occupancy (storage kept)
//   push        write push_data at tail
//   push_data   word to write
//   pop         advance head (ignored when empty)
//   valid       buffer non-empty
//   head_data   word at head
//   occupancy   number of stored words (0..DEPTH)
module fifo_stream_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = 2,
  localparam int PTR_W     = ptr_width(DEPTH),
  localparam int OCC_W     = ptr_width(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [OCC_W-1:0]      occupancy
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic                  pop_ok;

  // Pointer increment modulo DEPTH (DEPTH need not be a power of two).
  function automatic logic [PTR_W-1:0] adv(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign pop_ok    = pop & (occupancy != '0);
  assign valid     = (occupancy != '0);
  assign head_data = mem[head];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
    end else if (clr) begin
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
    end else begin
      if (push) begin
        mem[tail] <= push_data;
        tail      <= adv(tail);
      end
      if (pop_ok) head <= adv(head);
      case ({push, pop_ok})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a sync FIFO through its registered read port and presents the
// words as a full-throughput valid/ready stream via a small skid buffer.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   flush      drop buffered and in-flight words (xfer_cnt kept)
//   bus        FIFO read port + stream (master side)
//   xfer_cnt   wrapping count of delivered words
//   busy       buffer non-empty or pop in flight
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int BUF_DEPTH  = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  fifo_stream_reader_if.master   bus,
  output logic [CNT_WIDTH-1:0]   xfer_cnt,
  output logic                   busy
);

  localparam int OCC_W = ptr_width(BUF_DEPTH + 1);

  logic                  pend;
  logic                  deliver;
  logic                  buf_valid;
  logic [DATA_WIDTH-1:0] head_data;
  logic [OCC_W-1:0]      occupancy;
  logic [OCC_W:0]        committed;
  logic [OCC_W:0]        limit;

  assign deliver = buf_valid & bus.m_ready;

  // Credit: a pop is allowed while stored + in-flight words stay below the
  // buffer size, counting a word leaving this cycle as freed space. This
  // makes fifo_rd_en depend combinationally on m_ready, which is what keeps
  // the stream at one word per cycle.
  assign committed = {1'b0, occupancy} + {{OCC_W{1'b0}}, pend};
  assign limit     = (OCC_W + 1)'(BUF_DEPTH) + {{OCC_W{1'b0}}, deliver};

  assign bus.fifo_rd_en = ~rst & ~flush & ~bus.fifo_empty & (committed < limit);
  assign bus.m_valid    = buf_valid;
  assign bus.m_data     = head_data;
  assign busy           = buf_valid | pend;

  // pend marks a pop issued last cycle whose data is on fifo_rdata now.
  always_ff @(posedge clk) begin
    if (rst || flush) pend <= 1'b0;
    else              pend <= bus.fifo_rd_en;
  end

  // A delivery in a flush cycle still counts; only reset clears the count.
  always_ff @(posedge clk) begin
    if (rst)          xfer_cnt <= '0;
    else if (deliver) xfer_cnt <= xfer_cnt + CNT_WIDTH'(1);
  end

  fifo_stream_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .clr       (flush),
    .push      (pend & ~flush),
    .push_data (bus.fifo_rdata),
    .pop       (deliver),
    .valid     (buf_valid),
    .head_data (head_data),
    .occupancy (occupancy)
  );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a queue-based FIFO source, a queue model of
// the buffered words, per-cycle comparison plus literal scenario checks.
module tb_fifo_stream_reader;
  localparam int DW = 8;
  localparam int BD = 2;
  localparam int CW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic flush;
  always #5 clk = ~clk;

  fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus ();
  logic [CW-1:0] xfer_cnt;
  logic          busy;

  fifo_stream_reader #(
    .DATA_WIDTH (DW),
    .BUF_DEPTH  (BD),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .bus      (bus),
    .xfer_cnt (xfer_cnt),
    .busy     (busy)
  );

  // ---------------- model / scoreboard ----------------
  logic [DW-1:0] src_q[$];   // words sitting in the upstream FIFO
  logic [DW-1:0] exp_q[$];   // words the buffer must hold, head first
  logic [DW-1:0] got_q[$];   // words observed leaving on the stream
  logic          m_pend;
  logic [CW-1:0] m_cnt;
  int n_vec = 0;
  int n_fail = 0;
  int rd_run, rd_best, rd_total, v_run, v_best, v_total;
  logic s_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clr_stats();
    rd_run = 0; rd_best = 0; rd_total = 0;
    v_run = 0; v_best = 0; v_total = 0;
    got_q.delete();
  endtask

  // One clock cycle. Called at negedge+ with inputs already set; returns at
  // the next negedge after driving the FIFO read data for any accepted pop.
  task automatic step();
    int   room;
    logic dl, e_rd, e_valid, s_valid, s_busy;
    logic [DW-1:0] s_data;
    logic [CW-1:0] s_cnt;
    bus.fifo_empty = (src_q.size() == 0);
    #1;
    s_rd = bus.fifo_rd_en; s_valid = bus.m_valid; s_data = bus.m_data;
    s_busy = busy; s_cnt = xfer_cnt;
    e_valid = (exp_q.size() != 0);
    dl      = e_valid & bus.m_ready;
    room    = BD - exp_q.size() - int'(m_pend) + int'(dl);
    e_rd    = !rst && !flush && !bus.fifo_empty && (room > 0);
    chk("fifo_rd_en", 32'(s_rd), 32'(e_rd));
    chk("m_valid", 32'(s_valid), 32'(e_valid));
    if (e_valid) chk("m_data", 32'(s_data), 32'(exp_q[0]));
    chk("busy", 32'(s_busy), 32'(e_valid | m_pend));
    chk("xfer_cnt", 32'(s_cnt), 32'(m_cnt));
    if (s_valid && bus.m_ready) got_q.push_back(s_data);
    if (s_rd) begin rd_run++; rd_total++; end else rd_run = 0;
    if (s_valid) begin v_run++; v_total++; end else v_run = 0;
    if (rd_run > rd_best) rd_best = rd_run;
    if (v_run > v_best) v_best = v_run;
    // model next state
    if (rst) begin
      exp_q.delete(); m_pend = 1'b0; m_cnt = '0;
    end else begin
      if (dl) m_cnt = m_cnt + 1'b1;
      if (flush) begin
        exp_q.delete(); m_pend = 1'b0;
      end else begin
        if (dl) void'(exp_q.pop_front());
        if (m_pend) exp_q.push_back(bus.fifo_rdata);
        m_pend = e_rd;
      end
    end
    chk("no_overflow", 32'(exp_q.size() <= BD), 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (s_rd && src_q.size() != 0) bus.fifo_rdata = src_q.pop_front();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    rst = 1'b1; flush = 1'b0;
    bus.m_ready = 1'b0; bus.fifo_empty = 1'b1; bus.fifo_rdata = '0;
    m_pend = 1'b0; m_cnt = '0;
    clr_stats();
    @(negedge clk);
    run(2);
    rst = 1'b0;
    chk("reset_m_valid", 32'(bus.m_valid), 32'd0);
    chk("reset_m_data", 32'(bus.m_data), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_xfer_cnt", 32'(xfer_cnt), 32'd0);

    // Basic drain
    src_q = '{8'h11, 8'h22, 8'h33};
    bus.m_ready = 1'b1; clr_stats();
    run(8);
    chk("drain_count", 32'(got_q.size()), 32'd3);
    if (got_q.size() == 3) begin
      chk("drain_w0", 32'(got_q[0]), 32'h11);
      chk("drain_w1", 32'(got_q[1]), 32'h22);
      chk("drain_w2", 32'(got_q[2]), 32'h33);
    end
    chk("drain_valid_run", 32'(v_best), 32'd3);
    chk("drain_xfer_cnt", 32'(xfer_cnt), 32'd3);
    chk("drain_busy_low", 32'(busy), 32'd0);

    // Throughput
    for (int i = 0; i < 8; i++) src_q.push_back(8'hA0 + 8'(i));
    clr_stats();
    run(12);
    chk("tput_rd_run", 32'(rd_best), 32'd8);
    chk("tput_valid_run", 32'(v_best), 32'd8);
    chk("tput_count", 32'(got_q.size()), 32'd8);
    if (got_q.size() == 8) chk("tput_last", 32'(got_q[7]), 32'hA7);
    chk("tput_xfer_cnt", 32'(xfer_cnt), 32'd11);

    // Backpressure
    bus.m_ready = 1'b0;
    src_q = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
    clr_stats();
    run(5);
    chk("bp_pops", 32'(rd_total), 32'(BD));
    chk("bp_valid", 32'(bus.m_valid), 32'd1);
    chk("bp_head", 32'(bus.m_data), 32'hB0);
    bus.m_ready = 1'b1;
    run(8);
    chk("bp_count", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < got_q.size()) chk("bp_order", 32'(got_q[i]), 32'hB0 + 32'(i));
    chk("bp_xfer_cnt", 32'(xfer_cnt), 32'd15);

    // Empty guard
    clr_stats();
    for (int i = 0; i < 10; i++) begin
      bus.m_ready = 1'($urandom_range(0, 1));
      step();
    end
    chk("empty_rd_never", 32'(rd_total), 32'd0);
    chk("empty_valid_never", 32'(v_total), 32'd0);

    // Flush with pop in flight
    bus.m_ready = 1'b1; clr_stats();
    src_q.push_back(8'h55);
    step();
    chk("flush_pop_issued", 32'(s_rd), 32'd1);
    src_q.push_back(8'h66);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_rd_blocked", 32'(s_rd), 32'd0);
    chk("flush_valid_low", 32'(bus.m_valid), 32'd0);
    chk("flush_cnt_kept", 32'(xfer_cnt), 32'd15);
    run(4);
    chk("flush_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() == 1) chk("flush_next_word", 32'(got_q[0]), 32'h66);
    chk("flush_cnt_wrap", 32'(xfer_cnt), 32'd0);

    // Counter wrap from reset: 17 words into a 4-bit counter
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 17; i++) src_q.push_back(8'(i + 1));
    clr_stats();
    run(22);
    chk("wrap_count", 32'(got_q.size()), 32'd17);
    chk("wrap_xfer_cnt", 32'(xfer_cnt), 32'd1);

    // Reset mid-stream with two words buffered
    bus.m_ready = 1'b0;
    src_q = '{8'hC0, 8'hC1, 8'hC2};
    run(4);
    chk("mid_valid_before", 32'(bus.m_valid), 32'd1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("mid_rst_valid", 32'(bus.m_valid), 32'd0);
    chk("mid_rst_cnt", 32'(xfer_cnt), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_data", 32'(bus.m_data), 32'd0);
    bus.m_ready = 1'b1; clr_stats();
    run(4);
    chk("mid_rest_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() == 1) chk("mid_rest_word", 32'(got_q[0]), 32'hC2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
